// File: rtl/y_sched_pkg.sv
// Shared types and phase encodings for the Y SRAM bus scheduler.
package y_sched_pkg;

    localparam int unsigned PH_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_GAP_CW,
        ST_WRITE,
        ST_GAP_WC,
        ST_FINISH
    } state_t;

    // Mux select codes; 2'b11 is never driven.
    localparam logic [PH_W-1:0] PH_IDLE    = 2'b00;
    localparam logic [PH_W-1:0] PH_WRITE   = 2'b01;
    localparam logic [PH_W-1:0] PH_COMPUTE = 2'b10;

    function automatic logic [PH_W-1:0] phase_of(input state_t s);
        case (s)
            ST_COMPUTE: phase_of = PH_COMPUTE;
            ST_WRITE:   phase_of = PH_WRITE;
            default:    phase_of = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/y_phase_timer.sv
// Loadable down-counter shared by the turnaround gap and the phase watchdog.
module y_phase_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired_c
);

    logic [W-1:0] r_count;

    // Holds at zero so an idle or disabled watchdog never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/y_bus_scheduler.sv
// Sequences compute/write phases on the shared Y SRAM bus with gaps, watchdog and abort.
module y_bus_scheduler
    import y_sched_pkg::*;
#(
    parameter int unsigned ITER_W     = 8,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned TO_W       = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_start,
    input  logic [ITER_W-1:0] in_numIter,
    input  logic              in_computeDone,
    input  logic              in_writeDone,
    input  logic              in_abort,
    output logic              op_yComputeModuleEnable,
    output logic              op_yWriteModuleEnable,
    output logic              op_busy,
    output logic              op_done,
    output logic              op_timeout,
    output logic [ITER_W-1:0] op_iterCount
);

    // Timer must also hold the 4-bit gap count.
    localparam int unsigned TMR_W = (TO_W > 4) ? TO_W : 4;

    state_t            r_state;
    state_t            w_next;
    logic [ITER_W-1:0] r_num;
    logic [ITER_W-1:0] w_num_nxt;
    logic [ITER_W-1:0] r_iter;
    logic [ITER_W-1:0] w_iter_nxt;
    logic [ITER_W-1:0] w_iter_inc;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic [PH_W-1:0]   r_phase;
    logic              r_busy;
    logic              r_done;
    logic              w_load;
    logic [TMR_W-1:0]  w_load_val;
    logic              w_expired;
    logic              w_wdog_hit;

    y_phase_timer #(.W(TMR_W)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_en        (r_state != ST_IDLE),
        .o_expired_c (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_num     <= '0;
            r_iter    <= '0;
            r_timeout <= 1'b0;
            r_phase   <= PH_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_num     <= w_num_nxt;
            r_iter    <= w_iter_nxt;
            r_timeout <= w_timeout_nxt;
            r_phase   <= phase_of(w_next);
            r_busy    <= (w_next != ST_IDLE) && (w_next != ST_FINISH);
            r_done    <= (w_next == ST_FINISH);
        end
    end

    // Next state; abort beats watchdog beats done.
    always_comb begin
        w_next        = r_state;
        w_num_nxt     = r_num;
        w_iter_nxt    = r_iter;
        w_timeout_nxt = r_timeout;
        w_wdog_hit    = (TIMEOUT != 0) && w_expired;
        w_iter_inc    = (r_iter == {ITER_W{1'b1}}) ? r_iter : r_iter + ITER_W'(1);
        case (r_state)
            ST_IDLE: begin
                if (in_start) begin
                    w_num_nxt     = in_numIter;
                    w_iter_nxt    = '0;
                    w_timeout_nxt = 1'b0;
                    w_next        = (in_numIter == '0) ? ST_FINISH : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (in_abort) begin
                    w_next = ST_FINISH;
                end else if (w_wdog_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_next        = ST_FINISH;
                end else if (in_computeDone) begin
                    w_next = ST_GAP_CW;
                end
            end
            ST_GAP_CW: begin
                if (in_abort)       w_next = ST_FINISH;
                else if (w_expired) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (in_abort) begin
                    w_next = ST_FINISH;
                end else if (w_wdog_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_next        = ST_FINISH;
                end else if (in_writeDone) begin
                    w_iter_nxt = w_iter_inc;
                    w_next     = (w_iter_inc == r_num) ? ST_FINISH : ST_GAP_WC;
                end
            end
            ST_GAP_WC: begin
                if (in_abort)       w_next = ST_FINISH;
                else if (w_expired) w_next = ST_COMPUTE;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Reload the shared timer on every state change.
    always_comb begin
        w_load     = (w_next != r_state);
        w_load_val = ((w_next == ST_COMPUTE) || (w_next == ST_WRITE))
                   ? TMR_W'(TIMEOUT - 1) : TMR_W'(GAP_CYCLES - 1);
    end

    assign op_yComputeModuleEnable = r_phase[1];
    assign op_yWriteModuleEnable   = r_phase[0];
    assign op_busy                 = r_busy;
    assign op_done                 = r_done;
    assign op_timeout              = r_timeout;
    assign op_iterCount            = r_iter;

endmodule

// File: tb/tb_y_bus_scheduler.sv
// Directed cycle-by-cycle bench for y_bus_scheduler with an expected-output queue.
module tb_y_bus_scheduler;

    localparam int unsigned ITER_W = 8;

    typedef struct packed {
        logic              ce;
        logic              we;
        logic              busy;
        logic              done;
        logic              to;
        logic [ITER_W-1:0] iter;
    } exp_t;

    // Stimulus codes: {start, computeDone, writeDone, abort, reset_n}
    localparam logic [4:0] N    = 5'b00001;
    localparam logic [4:0] S    = 5'b10001;
    localparam logic [4:0] CD   = 5'b01001;
    localparam logic [4:0] WD   = 5'b00101;
    localparam logic [4:0] ABWD = 5'b00111;
    localparam logic [4:0] RS   = 5'b00000;
    localparam logic [1:0] E0   = 2'b00;
    localparam logic [1:0] EC   = 2'b10;
    localparam logic [1:0] EW   = 2'b01;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_start = 1'b0;
    logic [ITER_W-1:0] in_numIter = '0;
    logic              in_computeDone = 1'b0;
    logic              in_writeDone = 1'b0;
    logic              in_abort = 1'b0;
    logic              op_yComputeModuleEnable;
    logic              op_yWriteModuleEnable;
    logic              op_busy;
    logic              op_done;
    logic              op_timeout;
    logic [ITER_W-1:0] op_iterCount;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    y_bus_scheduler #(
        .ITER_W(ITER_W), .GAP_CYCLES(1), .TIMEOUT(8), .TO_W(4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_start                (in_start),
        .in_numIter              (in_numIter),
        .in_computeDone          (in_computeDone),
        .in_writeDone            (in_writeDone),
        .in_abort                (in_abort),
        .op_yComputeModuleEnable (op_yComputeModuleEnable),
        .op_yWriteModuleEnable   (op_yWriteModuleEnable),
        .op_busy                 (op_busy),
        .op_done                 (op_done),
        .op_timeout              (op_timeout),
        .op_iterCount            (op_iterCount)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, then check the outputs registered at its closing edge.
    task automatic cyc(input string tag, input logic [4:0] stim, input logic [ITER_W-1:0] num,
                       input logic [1:0] en, input logic busy, input logic done,
                       input logic to, input logic [ITER_W-1:0] iter);
        exp_t e;
        exp_t obs;
        sb.push_back(exp_t'{ce: en[1], we: en[0], busy: busy, done: done, to: to, iter: iter});
        {in_start, in_computeDone, in_writeDone, in_abort, reset} = stim;
        in_numIter = num;
        @(posedge clk);
        #1;
        {in_start, in_computeDone, in_writeDone, in_abort} = 4'b0000;
        reset = 1'b1;
        obs = exp_t'{ce: op_yComputeModuleEnable, we: op_yWriteModuleEnable, busy: op_busy,
                     done: op_done, to: op_timeout, iter: op_iterCount};
        e = sb.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed ce/we/busy/done/to/iter=%b expected=%b", tag, obs, e);
        end
        checks++;
        assert (!(op_yComputeModuleEnable && op_yWriteModuleEnable)) else begin
            errors++;
            $error("FAIL %s_excl: observed enables=11 expected not 11", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        cyc("reset0", RS, 0, E0, 0, 0, 0, 0);
        cyc("reset1", RS, 0, E0, 0, 0, 0, 0);

        // Normal two-iteration run; start is cycle 0.
        cyc("n_start", S, 2, EC, 1, 0, 0, 0);
        repeat (4) cyc("n_c1", N, 0, EC, 1, 0, 0, 0);
        cyc("n_cd1", CD, 0, E0, 1, 0, 0, 0);
        cyc("n_gap1", N, 0, EW, 1, 0, 0, 0);
        repeat (2) cyc("n_w1", N, 0, EW, 1, 0, 0, 0);
        cyc("n_wd1", WD, 0, E0, 1, 0, 0, 1);
        cyc("n_gap2", N, 0, EC, 1, 0, 0, 1);
        repeat (4) cyc("n_c2", N, 0, EC, 1, 0, 0, 1);
        cyc("n_cd2", CD, 0, E0, 1, 0, 0, 1);
        cyc("n_gap3", N, 0, EW, 1, 0, 0, 1);
        repeat (2) cyc("n_w2", N, 0, EW, 1, 0, 0, 1);
        cyc("n_done", WD, 0, E0, 0, 1, 0, 2);
        cyc("n_idle", N, 0, E0, 0, 0, 0, 2);

        // Zero iterations.
        cyc("z_done", S, 0, E0, 0, 1, 0, 0);
        cyc("z_idle", N, 0, E0, 0, 0, 0, 0);

        // Wrong-phase dones are ignored.
        cyc("wp_start", S, 1, EC, 1, 0, 0, 0);
        cyc("wp_wd_in_c", WD, 0, EC, 1, 0, 0, 0);
        cyc("wp_cd", CD, 0, E0, 1, 0, 0, 0);
        cyc("wp_gap", N, 0, EW, 1, 0, 0, 0);
        cyc("wp_cd_in_w", CD, 0, EW, 1, 0, 0, 0);
        cyc("wp_done", WD, 0, E0, 0, 1, 0, 1);
        cyc("wp_idle", N, 0, E0, 0, 0, 0, 1);

        // Watchdog: compute enable high for exactly 8 cycles.
        cyc("wd_start", S, 1, EC, 1, 0, 0, 0);
        repeat (7) cyc("wd_c", N, 0, EC, 1, 0, 0, 0);
        cyc("wd_expire", N, 0, E0, 0, 1, 1, 0);
        cyc("wd_sticky", N, 0, E0, 0, 0, 1, 0);
        cyc("wd_restart", S, 1, EC, 1, 0, 0, 0);
        repeat (7) cyc("wd_c2", N, 0, EC, 1, 0, 0, 0);
        cyc("wd_tie", CD, 0, E0, 0, 1, 1, 0);
        cyc("wd_sticky2", N, 0, E0, 0, 0, 1, 0);
        cyc("wd_clear", S, 0, E0, 0, 1, 0, 0);
        cyc("wd_idle", N, 0, E0, 0, 0, 0, 0);

        // Abort wins over a simultaneous writeDone.
        cyc("ab_start", S, 3, EC, 1, 0, 0, 0);
        cyc("ab_cd", CD, 0, E0, 1, 0, 0, 0);
        cyc("ab_gap", N, 0, EW, 1, 0, 0, 0);
        cyc("ab_abort", ABWD, 0, E0, 0, 1, 0, 0);
        cyc("ab_idle", N, 0, E0, 0, 0, 0, 0);

        // Reset during WRITE of the second iteration.
        cyc("r_start", S, 3, EC, 1, 0, 0, 0);
        cyc("r_cd1", CD, 0, E0, 1, 0, 0, 0);
        cyc("r_gap1", N, 0, EW, 1, 0, 0, 0);
        cyc("r_wd1", WD, 0, E0, 1, 0, 0, 1);
        cyc("r_gap2", N, 0, EC, 1, 0, 0, 1);
        cyc("r_cd2", CD, 0, E0, 1, 0, 0, 1);
        cyc("r_gap3", N, 0, EW, 1, 0, 0, 1);
        cyc("r_reset", RS, 0, E0, 0, 0, 0, 0);
        cyc("r_idle", N, 0, E0, 0, 0, 0, 0);

        // Start while busy or in FINISH is ignored.
        cyc("b_start", S, 2, EC, 1, 0, 0, 0);
        cyc("b_cd1", CD, 0, E0, 1, 0, 0, 0);
        cyc("b_gap1", N, 0, EW, 1, 0, 0, 0);
        cyc("b_wd1", WD, 0, E0, 1, 0, 0, 1);
        cyc("b_start_gap", S, 1, EC, 1, 0, 0, 1);
        cyc("b_start_c", S, 1, EC, 1, 0, 0, 1);
        cyc("b_cd2", CD, 0, E0, 1, 0, 0, 1);
        cyc("b_gap2", N, 0, EW, 1, 0, 0, 1);
        cyc("b_done", WD, 0, E0, 0, 1, 0, 2);
        cyc("b_start_fin", S, 1, E0, 0, 0, 0, 2);
        cyc("b_idle", N, 0, E0, 0, 0, 0, 2);
        cyc("b_restart", S, 0, E0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y_bus_scheduler.md
Name: y_bus_scheduler

Overview:
- Sequences access to the shared Y SRAM bus multiplexer.
- Generates the two mutually exclusive phase enables that drive the mux select: the compute-path enable (yCompute) and the write-path enable (yWrite).
- Runs N iterations of compute phase → turnaround gap → write phase → turnaround gap, using done handshakes from each path.
- Includes a per-phase watchdog and an abort input.

Parameters:
- ITER_W, 8: width of the iteration count and iteration counter.
- GAP_CYCLES, 1: idle cycles with both enables low between phases. Legal range 1..15.
- TIMEOUT, 1024: maximum cycles allowed in one phase before error. 0 disables the watchdog.
- TO_W, 11: watchdog counter width. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- in_start  in  1  single-cycle pulse; begins a run when idle.
- in_numIter  in  ITER_W  iteration count; sampled on an accepted start.
- in_computeDone  in  1  compute path has finished its phase. Level or pulse.
- in_writeDone  in  1  write path has finished its phase. Level or pulse.
- in_abort  in  1  terminates the run at the next edge.
- op_yComputeModuleEnable  out  1  compute-path phase enable; registered.
- op_yWriteModuleEnable  out  1  write-path phase enable; registered.
- op_busy  out  1  high from the cycle after an accepted start until the cycle before op_done.
- op_done  out  1  one-cycle pulse at the end of a run (normal, abort or timeout).
- op_timeout  out  1  sticky watchdog error flag; cleared by reset or the next accepted start.
- op_iterCount  out  ITER_W  number of completed iterations in the current/last run.

Behaviour:
- All outputs are registered. Reset (reset=0 at an edge) forces: both enables 0, op_busy 0, op_done 0, op_timeout 0, op_iterCount 0, state IDLE. This applies mid-run too; handshakes in flight are dropped.
- Invariant: the two enables are never 1 in the same cycle (never the 2'b11 mux code). After any phase ends, both enables are 0 for exactly GAP_CYCLES cycles before the next phase starts.
- States: IDLE, COMPUTE, GAP_CW, WRITE, GAP_WC, FINISH.
- IDLE:
  - in_start=1 with in_numIter≠0 → COMPUTE. Latch numIter, clear iterCount and op_timeout.
  - The compute enable is high in the first cycle after the start edge (latency 1).
  - in_numIter=0 → FINISH directly; no enable is ever asserted.
- COMPUTE (compute enable=1):
  - in_computeDone=1 → GAP_CW; the enable drops the next cycle.
  - in_writeDone is ignored in this state.
- GAP_CW: count GAP_CYCLES, then → WRITE.
- WRITE (write enable=1):
  - in_writeDone=1 → increment iterCount.
  - If the new count equals numIter → FINISH; else → GAP_WC.
  - in_computeDone is ignored in this state.
- GAP_WC: count GAP_CYCLES, then → COMPUTE.
- FINISH: op_done=1 for one cycle, op_busy=0, → IDLE.
- Start handling: in_start outside IDLE is ignored. in_start during FINISH is ignored; the earliest restart is the cycle after op_done.
- Watchdog:
  - The counter clears on every phase entry and increments each cycle in COMPUTE/WRITE.
  - Reaching TIMEOUT with no done → op_timeout=1, enables drop, → FINISH.
- Abort: in_abort=1 in any non-IDLE, non-FINISH state → FINISH. Enables drop at the next edge; iterCount is held.
- Priority at one edge: reset > abort > timeout > done. A done on the same edge the watchdog expires counts as timeout.
- iterCount saturates at its maximum and never wraps; this is unreachable since the count is bounded by numIter.

Decomposition:
- Shared package y_sched_pkg holds:
  - the state enum typedef;
  - the 2-bit phase-code constants PH_IDLE=2'b00, PH_WRITE=2'b01, PH_COMPUTE=2'b10, matching the mux select encoding.
- One natural sub-module: y_phase_timer. It is a loadable down-counter reused for both the gap count and the watchdog, with load/enable/expired ports.
- The FSM stays in the top module.

Test Plan:
- Normal run:
  - Stimulus: in_numIter=2, start at cycle 0; computeDone at cycles 5 and 15; writeDone at cycles 9 and 19.
  - Required: compute enable high cycles 1-5 and 11-15; write enable high cycles 7-9 and 17-19; both low at cycles 6, 10 and 16 (GAP_CYCLES=1).
  - Required: op_done at cycle 20, iterCount=2, and enables never both high.
- Zero iterations:
  - Stimulus: in_numIter=0, start.
  - Required: op_done one cycle after start; enables stay 0; iterCount=0.
- Wrong-phase done:
  - Stimulus: writeDone asserted during COMPUTE, computeDone asserted during WRITE.
  - Required: both ignored; the state does not advance.
- Watchdog:
  - Stimulus: TIMEOUT=8; no computeDone after start.
  - Required: compute enable drops after 8 cycles; op_timeout=1 and op_done pulse; next start clears op_timeout.
- Abort with simultaneous done:
  - Stimulus: abort together with writeDone in WRITE of iteration 1 of 3.
  - Required: FINISH with iterCount=0 (abort wins over done); op_done pulse.
- Reset mid-run and start while busy:
  - Stimulus: reset=0 for 1 cycle during WRITE.
  - Required: all outputs 0 next cycle; state IDLE.
  - Stimulus: in_start while busy.
  - Required: no effect on numIter or iterCount.
